sys_step_ctrl: RTL and testbench

//  Upstream execution controller for the single-cycle MIPS system. Debounces board keys and switches and

---
 rtl/sys_pkg.sv | 26 ++
 rtl/sys_step_ctrl_if.sv | 31 +++
 rtl/sys_debounce.sv | 58 +++++
 rtl/sys_step_ctrl.sv | 152 +++++++++++++++
 tb/tb_sys_step_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_pkg
// Purpose  : Shared state encodings and default timing constants for the
//            single-cycle MIPS execution controller.
// Revision : 1.0
// ============================================================================
package sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int c_DB_CYCLES_DEF = 500000;
    localparam int c_RUN_DIV_DEF   = 25000000;
    localparam int c_PC_W_DEF      = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_step_ctrl_if
// Purpose  : Board/CPU-facing signal bundle of the execution controller.
// Revision : 1.0
// ============================================================================
interface sys_step_ctrl_if #(
    parameter int PC_W = 8
);
    logic            KEY_step;
    logic            KEY_load;
    logic            SW_run;
    logic [PC_W-1:0] SW_pc_val;
    logic            EH_flag;
    logic            CPU_step;
    logic            PC_load;
    logic [PC_W-1:0] PC_load_val;
    logic [15:0]     STEP_cnt;
    logic            HALT_led;

    modport master (
        output KEY_step, KEY_load, SW_run, SW_pc_val, EH_flag,
        input  CPU_step, PC_load, PC_load_val, STEP_cnt, HALT_led
    );

    modport slave (
        input  KEY_step, KEY_load, SW_run, SW_pc_val, EH_flag,
        output CPU_step, PC_load, PC_load_val, STEP_cnt, HALT_led
    );
endinterface
`default_nettype wire

// File: rtl/sys_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sys_debounce
// Purpose  : Two-flop synchronizer, stability debouncer and one-cycle
//            falling-edge (press) event for one raw board input.
// Revision : 1.0
// ============================================================================
module sys_debounce
    import sys_pkg::*;
#(
    parameter int   DB_CYCLES = c_DB_CYCLES_DEF,
    parameter logic RST_LEVEL = 1'b1
) (
    input  wire logic SYS_clk,
    input  wire logic SYS_rst,
    input  wire logic i_raw,
    output logic      o_level,
    output logic      o_fall
);

    localparam int                c_CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_fall;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge SYS_clk) begin
        if (SYS_rst) begin
            r_sync1  <= RST_LEVEL;
            r_sync2  <= RST_LEVEL;
            r_stable <= RST_LEVEL;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            // Any return to the stable level restarts the stability window.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_fall   <= r_stable & ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/sys_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_step_ctrl
// Purpose  : Manual single-step / free-run controller issuing CPU_step and
//            PC_load pulses, halting free-run on a CPU exception.
// Revision : 1.0
// ============================================================================
module sys_step_ctrl
    import sys_pkg::*;
#(
    parameter int DB_CYCLES = c_DB_CYCLES_DEF,
    parameter int RUN_DIV   = c_RUN_DIV_DEF,
    parameter int PC_W      = c_PC_W_DEF
) (
    input  wire logic      SYS_clk,
    input  wire logic      SYS_rst,
    sys_step_ctrl_if.slave bus
);

    localparam int                c_DIV_W   = cnt_width(RUN_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(RUN_DIV - 1);

    logic w_step_ev;
    logic w_step_lvl;
    logic w_load_ev;
    logic w_load_lvl;
    logic w_run_lvl;
    logic w_run_fall;
    logic w_unused_ok;

    sys_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LEVEL(1'b1)) u_db_step (
        .SYS_clk (SYS_clk),
        .SYS_rst (SYS_rst),
        .i_raw   (bus.KEY_step),
        .o_level (w_step_lvl),
        .o_fall  (w_step_ev)
    );

    sys_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LEVEL(1'b1)) u_db_load (
        .SYS_clk (SYS_clk),
        .SYS_rst (SYS_rst),
        .i_raw   (bus.KEY_load),
        .o_level (w_load_lvl),
        .o_fall  (w_load_ev)
    );

    sys_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LEVEL(1'b0)) u_db_run (
        .SYS_clk (SYS_clk),
        .SYS_rst (SYS_rst),
        .i_raw   (bus.SW_run),
        .o_level (w_run_lvl),
        .o_fall  (w_run_fall)
    );

    assign w_unused_ok = &{1'b0, w_step_lvl, w_load_lvl, w_run_fall};

    logic [PC_W-1:0]    r_pc_sync1;
    logic [PC_W-1:0]    r_pc_sync2;
    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic               r_cpu_step;
    logic               r_pc_load;
    logic [PC_W-1:0]    r_pc_load_val;
    logic [15:0]        r_step_cnt;
    logic               r_halt_led;

    // The PC value only needs to be settled by the time the load key has
    // debounced, so it is synchronized but not filtered.
    always_ff @(posedge SYS_clk) begin
        if (SYS_rst) begin
            r_pc_sync1 <= '0;
            r_pc_sync2 <= '0;
        end else begin
            r_pc_sync1 <= bus.SW_pc_val;
            r_pc_sync2 <= r_pc_sync1;
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_rst) begin
            r_state       <= ST_IDLE;
            r_div         <= '0;
            r_cpu_step    <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_load_val <= '0;
            r_step_cnt    <= '0;
            r_halt_led    <= 1'b0;
        end else begin
            r_cpu_step <= 1'b0;
            r_pc_load  <= 1'b0;
            // A load pre-empts everything else; a coincident step is lost.
            if (w_load_ev) begin
                r_pc_load     <= 1'b1;
                r_pc_load_val <= r_pc_sync2;
                r_step_cnt    <= '0;
                r_div         <= '0;
                if (r_state == ST_HALT) begin
                    r_state    <= ST_IDLE;
                    r_halt_led <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_step_ev) begin
                            r_cpu_step <= 1'b1;
                            r_step_cnt <= r_step_cnt + 16'd1;
                        end
                        if (w_run_lvl) begin
                            r_state <= ST_RUN;
                            r_div   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (!w_run_lvl) begin
                            r_state <= ST_IDLE;
                            r_div   <= '0;
                        end else if (r_div == c_DIV_MAX) begin
                            r_div <= '0;
                            if (!bus.EH_flag) begin
                                r_cpu_step <= 1'b1;
                                r_step_cnt <= r_step_cnt + 16'd1;
                            end else begin
                                r_state    <= ST_HALT;
                                r_halt_led <= 1'b1;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                    ST_HALT: begin
                        if (w_step_ev) begin
                            r_state    <= ST_IDLE;
                            r_halt_led <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_halt_led <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.CPU_step    = r_cpu_step;
    assign bus.PC_load     = r_pc_load;
    assign bus.PC_load_val = r_pc_load_val;
    assign bus.STEP_cnt    = r_step_cnt;
    assign bus.HALT_led    = r_halt_led;

endmodule
`default_nettype wire

// File: tb/tb_sys_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_step_ctrl
// Purpose  : Scoreboard bench for sys_step_ctrl with short debounce/divider.
// Revision : 1.0
// ============================================================================
module tb_sys_step_ctrl;

    localparam int DB = 4;
    localparam int RD = 3;
    localparam int PW = 8;

    logic SYS_clk = 1'b0;
    logic SYS_rst = 1'b1;

    sys_step_ctrl_if #(.PC_W(PW)) bus ();

    sys_step_ctrl #(.DB_CYCLES(DB), .RUN_DIV(RD), .PC_W(PW)) dut (
        .SYS_clk (SYS_clk),
        .SYS_rst (SYS_rst),
        .bus     (bus)
    );

    always #5 SYS_clk = ~SYS_clk;

    int cyc = 0;
    always @(posedge SYS_clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          is_load;
        logic [7:0]  val;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input bit is_load, input logic [7:0] val, input logic [15:0] cnt);
        exp_t e;
        e.at      = at;
        e.is_load = is_load;
        e.val     = val;
        e.cnt     = cnt;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge SYS_clk);
            #1;
        end
    endtask

    task automatic wait_n(input int n);
        goto(cyc + n);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge SYS_clk) begin : mon
        exp_t e;
        if (bus.CPU_step === 1'b1 || bus.PC_load === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'({bus.CPU_step, bus.PC_load}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.at));
                chk("pulse_kind", 32'({bus.CPU_step, bus.PC_load}), e.is_load ? 32'd1 : 32'd2);
                if (e.is_load) chk("pulse_load_val", 32'(bus.PC_load_val), 32'(e.val));
                chk("pulse_step_cnt", 32'(bus.STEP_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a;
        int b;
        bus.KEY_step  = 1'b1;
        bus.KEY_load  = 1'b1;
        bus.SW_run    = 1'b0;
        bus.SW_pc_val = '0;
        bus.EH_flag   = 1'b0;
        SYS_rst       = 1'b1;

        // Reset values, then keys held during a long reset
        goto(2);
        chk("rst_cpu_step", 32'(bus.CPU_step), 32'd0);
        chk("rst_pc_load", 32'(bus.PC_load), 32'd0);
        chk("rst_pc_load_val", 32'(bus.PC_load_val), 32'd0);
        chk("rst_step_cnt", 32'(bus.STEP_cnt), 32'd0);
        chk("rst_halt_led", 32'(bus.HALT_led), 32'd0);
        bus.KEY_step = 1'b0;
        bus.KEY_load = 1'b0;
        goto(12);
        bus.KEY_step = 1'b1;
        bus.KEY_load = 1'b1;
        goto(14);
        SYS_rst = 1'b0;
        goto(30);
        chk("post_rst_step_cnt", 32'(bus.STEP_cnt), 32'd0);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        // Bounce on KEY_step, then held low
        for (int i = 0; i < 8; i++) begin
            bus.KEY_step = i[0];
            wait_n(1);
        end
        bus.KEY_step = 1'b0;
        a = cyc;
        push(a + 7, 1'b0, 8'h00, 16'd1);
        goto(a + 20);
        bus.KEY_step = 1'b1;
        wait_n(12);
        chk("bounce_sb_empty", 32'(sb.size()), 32'd0);
        chk("bounce_step_cnt", 32'(bus.STEP_cnt), 32'd1);

        // PC load
        bus.SW_pc_val = 8'h2A;
        wait_n(3);
        bus.KEY_load = 1'b0;
        a = cyc;
        push(a + 7, 1'b1, 8'h2A, 16'd0);
        goto(a + 12);
        chk("load_val_held", 32'(bus.PC_load_val), 32'h2A);
        bus.KEY_load = 1'b1;
        wait_n(12);
        chk("load_sb_empty", 32'(sb.size()), 32'd0);

        // Free-run, exception halt, step acknowledge
        bus.SW_run = 1'b1;
        a = cyc;
        push(a + 10, 1'b0, 8'h00, 16'd1);
        push(a + 13, 1'b0, 8'h00, 16'd2);
        push(a + 16, 1'b0, 8'h00, 16'd3);
        goto(a + 17);
        bus.EH_flag = 1'b1;
        goto(a + 20);
        chk("halt_led_set", 32'(bus.HALT_led), 32'd1);
        bus.SW_run = 1'b0;
        goto(a + 27);
        chk("halt_led_hold", 32'(bus.HALT_led), 32'd1);
        bus.KEY_step = 1'b0;
        b = cyc;
        goto(b + 6);
        chk("halt_before_ack", 32'(bus.HALT_led), 32'd1);
        goto(b + 7);
        chk("halt_led_clear", 32'(bus.HALT_led), 32'd0);
        bus.EH_flag  = 1'b0;
        bus.KEY_step = 1'b1;
        wait_n(12);
        chk("run_sb_empty", 32'(sb.size()), 32'd0);
        chk("run_step_cnt", 32'(bus.STEP_cnt), 32'd3);

        // Step and load in the same cycle
        bus.SW_pc_val = 8'h55;
        wait_n(3);
        bus.KEY_step = 1'b0;
        bus.KEY_load = 1'b0;
        a = cyc;
        push(a + 7, 1'b1, 8'h55, 16'd0);
        goto(a + 12);
        bus.KEY_step = 1'b1;
        bus.KEY_load = 1'b1;
        wait_n(12);
        chk("coll_sb_empty", 32'(sb.size()), 32'd0);
        chk("coll_step_cnt", 32'(bus.STEP_cnt), 32'd0);

        // STEP_cnt wrap from 0xFFFF
        force dut.r_step_cnt = 16'hFFFF;
        @(negedge SYS_clk);
        release dut.r_step_cnt;
        wait_n(1);
        chk("preload_step_cnt", 32'(bus.STEP_cnt), 32'hFFFF);
        bus.KEY_step = 1'b0;
        a = cyc;
        push(a + 7, 1'b0, 8'h00, 16'h0000);
        goto(a + 12);
        bus.KEY_step = 1'b1;
        wait_n(12);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a free-run divider count
        bus.SW_run = 1'b1;
        a = cyc;
        push(a + 10, 1'b0, 8'h00, 16'd1);
        push(a + 13, 1'b0, 8'h00, 16'd2);
        goto(a + 14);
        SYS_rst    = 1'b1;
        bus.SW_run = 1'b0;
        goto(a + 16);
        SYS_rst = 1'b0;
        goto(a + 40);
        chk("midrst_step_cnt", 32'(bus.STEP_cnt), 32'd0);
        chk("midrst_pc_load_val", 32'(bus.PC_load_val), 32'd0);
        chk("midrst_halt_led", 32'(bus.HALT_led), 32'd0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
